// File: rtl/mem_arb_pkg.sv
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DRD  = 2'd2,
    OWN_DWR  = 2'd3
  } owner_e;

  function automatic int unsigned STARVE_CNT_W(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_if_valid,
  input  logic       i_if_flush,
  input  logic       i_d_valid,
  output logic [1:0] o_gnt
);

  localparam int unsigned CW = STARVE_CNT_W(STARVE_LIMIT);

  logic [CW-1:0] r_starve_cnt;
  logic          w_if_elig;
  logic          w_starved;

  assign w_if_elig = i_if_valid & ~i_if_flush;
  assign w_starved = (r_starve_cnt == CW'(STARVE_LIMIT));

  // bit 0 = fetch, bit 1 = data
  always_comb begin
    o_gnt = '0;
    if (!rst_n) begin
      o_gnt = '0;
    end else if (w_starved && w_if_elig) begin
      o_gnt = 2'b01;
    end else if (i_d_valid) begin
      o_gnt = 2'b10;
    end else if (w_if_elig) begin
      o_gnt = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (!i_if_valid || o_gnt[0]) begin
      r_starve_cnt <= '0;
    end else if (!w_starved) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DW           = 32,
  parameter int unsigned AW           = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req_valid,
  output logic          if_req_ready,
  input  logic [AW-1:0] if_req_addr,
  input  logic          if_flush,
  output logic          if_rsp_valid,
  output logic [DW-1:0] if_rsp_data,
  input  logic          d_req_valid,
  output logic          d_req_ready,
  input  logic          d_req_we,
  input  logic [AW-1:0] d_req_addr,
  input  logic [DW-1:0] d_req_wdata,
  output logic          d_rsp_valid,
  output logic [DW-1:0] d_rsp_data,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_write_data,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_read_data
);

  logic [1:0] w_gnt;
  owner_e     r_owner;
  owner_e     w_own_nxt;

  mem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_if_valid(if_req_valid),
    .i_if_flush(if_flush),
    .i_d_valid (d_req_valid),
    .o_gnt     (w_gnt)
  );

  assign if_req_ready = w_gnt[0];
  assign d_req_ready  = w_gnt[1];

  always_comb begin
    mem_address    = '0;
    mem_write_data = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    w_own_nxt      = OWN_NONE;
    if (w_gnt[0]) begin
      mem_address = if_req_addr;
      mem_read    = 1'b1;
      w_own_nxt   = OWN_IF;
    end else if (w_gnt[1]) begin
      mem_address = d_req_addr;
      if (d_req_we) begin
        mem_write      = 1'b1;
        mem_write_data = d_req_wdata;
        w_own_nxt      = OWN_DWR;
      end else begin
        mem_read  = 1'b1;
        w_own_nxt = OWN_DRD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= OWN_NONE;
    end else begin
      r_owner <= w_own_nxt;
    end
  end

  always_comb begin
    if_rsp_valid = 1'b0;
    if_rsp_data  = '0;
    d_rsp_valid  = 1'b0;
    d_rsp_data   = '0;
    if (rst_n) begin
      case (r_owner)
        OWN_IF: begin
          if_rsp_valid = ~if_flush;
          if_rsp_data  = mem_read_data;
        end
        OWN_DRD: begin
          d_rsp_valid = 1'b1;
          d_rsp_data  = mem_read_data;
        end
        OWN_DWR: begin
          d_rsp_valid = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 64;
  localparam int unsigned LIM = 4;

  localparam int G_NONE = 0;
  localparam int G_IF   = 1;
  localparam int G_D    = 2;

  localparam int K_NONE = 0;
  localparam int K_IF   = 1;
  localparam int K_DRD  = 2;
  localparam int K_DWR  = 3;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req_valid = 1'b0;
  logic          if_req_ready;
  logic [AW-1:0] if_req_addr = '0;
  logic          if_flush = 1'b0;
  logic          if_rsp_valid;
  logic [DW-1:0] if_rsp_data;
  logic          d_req_valid = 1'b0;
  logic          d_req_ready;
  logic          d_req_we = 1'b0;
  logic [AW-1:0] d_req_addr = '0;
  logic [DW-1:0] d_req_wdata = '0;
  logic          d_rsp_valid;
  logic [DW-1:0] d_rsp_data;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_read_data;

  logic [31:0] mem_arr [64];
  logic [31:0] shadow  [64];
  rsp_t        rspq [$];
  int          vectors = 0;
  int          miscompares = 0;
  int          exp_cnt = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .DW(DW),
    .AW(AW),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_req_addr   (if_req_addr),
    .if_flush      (if_flush),
    .if_rsp_valid  (if_rsp_valid),
    .if_rsp_data   (if_rsp_data),
    .d_req_valid   (d_req_valid),
    .d_req_ready   (d_req_ready),
    .d_req_we      (d_req_we),
    .d_req_addr    (d_req_addr),
    .d_req_wdata   (d_req_wdata),
    .d_rsp_valid   (d_rsp_valid),
    .d_rsp_data    (d_rsp_data),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_read_data (mem_read_data)
  );

  // single-port memory with one-cycle read latency
  always @(posedge clk) begin
    if (mem_write) mem_arr[mem_address[7:2]] <= mem_write_data;
    if (mem_read)  mem_read_data <= mem_arr[mem_address[7:2]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [63:0] ia, input logic fl,
                      input logic dv, input logic we, input logic [63:0] da,
                      input logic [31:0] wd, input int eg);
    rsp_t e;
    rsp_t n;
    logic is_if;
    logic is_d;
    @(negedge clk);
    if_req_valid = iv;
    if_req_addr  = ia;
    if_flush     = fl;
    d_req_valid  = dv;
    d_req_we     = we;
    d_req_addr   = da;
    d_req_wdata  = wd;
    #1;
    if (rspq.size() > 0) e = rspq.pop_front();
    else begin
      e.kind = K_NONE;
      e.data = '0;
    end
    is_if = (e.kind == K_IF) && !fl;
    is_d  = (e.kind == K_DRD) || (e.kind == K_DWR);
    chk("if_rsp_valid", if_rsp_valid, is_if);
    if (is_if) chk("if_rsp_data", if_rsp_data, e.data);
    chk("d_rsp_valid", d_rsp_valid, is_d);
    if (is_d) chk("d_rsp_data", d_rsp_data, e.data);
    chk("if_req_ready", if_req_ready, eg == G_IF);
    chk("d_req_ready", d_req_ready, eg == G_D);
    chk("mem_read", mem_read, (eg == G_IF) || (eg == G_D && !we));
    chk("mem_write", mem_write, eg == G_D && we);
    chk("mem_address", mem_address, (eg == G_IF) ? ia : (eg == G_D) ? da : 64'h0);
    chk("mem_write_data", mem_write_data, (eg == G_D && we) ? {32'h0, wd} : 64'h0);
    chk("starve_cnt", 64'(dut.u_prio.r_starve_cnt), 64'(exp_cnt));
    n.kind = K_NONE;
    n.data = '0;
    if (eg == G_IF) begin
      n.kind = K_IF;
      n.data = shadow[ia[7:2]];
    end else if (eg == G_D && we) begin
      n.kind = K_DWR;
      shadow[da[7:2]] = wd;
    end else if (eg == G_D) begin
      n.kind = K_DRD;
      n.data = shadow[da[7:2]];
    end
    rspq.push_back(n);
    if (!iv || eg == G_IF) exp_cnt = 0;
    else if (exp_cnt < int'(LIM)) exp_cnt++;
  endtask

  task automatic idle();
    step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0, G_NONE);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_if_req_ready", if_req_ready, 1'b0);
    chk("rst_d_req_ready", d_req_ready, 1'b0);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_if_rsp_valid", if_rsp_valid, 1'b0);
    chk("rst_d_rsp_valid", d_rsp_valid, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_arr[i] = 32'hA5A5_0000 + 32'(i);
      shadow[i]  = 32'hA5A5_0000 + 32'(i);
    end

    // reset state, with requests driven
    if_req_valid = 1'b1;
    d_req_valid  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    chk("rst_owner", 64'(dut.r_owner), 64'(OWN_NONE));
    chk("rst_starve", 64'(dut.u_prio.r_starve_cnt), 64'h0);
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    rst_n = 1'b1;

    // fetch 0x10, 0x14 back to back
    step(1'b1, 64'h10, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0, G_IF);
    step(1'b1, 64'h14, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0, G_IF);
    idle();

    // store then load the same address
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 64'h20, 32'hDEAD_BEEF, G_D);
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h20, 32'h0, G_D);
    idle();

    // contention: fetch wins every fifth cycle
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 64'h30, 1'b0, 1'b1, 1'b0, 64'h40 + 64'(4 * i), 32'h0,
           (i % 5 == 4) ? G_IF : G_D);
    end
    idle();

    // flush during fetch response, then flush during load response
    step(1'b1, 64'h18, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0, G_IF);
    step(1'b1, 64'h18, 1'b1, 1'b1, 1'b0, 64'h24, 32'h0, G_D);
    step(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 32'h0, G_NONE);
    idle();

    // reset in the cycle after a load grant drops the response
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h28, 32'h0, G_D);
    @(negedge clk);
    rst_n        = 1'b0;
    if_req_valid = 1'b1;
    d_req_valid  = 1'b1;
    d_req_we     = 1'b1;
    #1;
    chk_reset_outputs();
    rspq.delete();
    exp_cnt = 0;
    @(negedge clk);
    #1;
    chk_reset_outputs();
    chk("rst2_owner", 64'(dut.r_owner), 64'(OWN_NONE));
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    d_req_we     = 1'b0;
    rst_n = 1'b1;
    idle();
    chk("post_rst_owner", 64'(dut.r_owner), 64'(OWN_NONE));

    // idle: no strobes, no responses, counter at 0
    repeat (4) idle();
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h14, 32'h0, G_D);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
